// File: rtl/db_ram_1p_ctrl_pkg.sv
// Shared constants and encodings for the deblocking line-buffer RAM controller.
package db_ram_1p_ctrl_pkg;

  localparam int unsigned DB_RAM_WW = 20;
  localparam int unsigned DB_RAM_AW = 8;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } db_state_e;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } db_pri_e;

endpackage

// File: rtl/db_resp_fifo.sv
// Two-entry synchronous response FIFO; push and pop may coincide.
module db_resp_fifo #(
  parameter int unsigned Width = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] dat_i,
  output logic             val_o,
  output logic [Width-1:0] dat_o,
  output logic [1:0]       cnt_o
);

  logic [Width-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop_i && (r_cnt != 2'd0);
  assign w_push = push_i && ((r_cnt != 2'd2) || w_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= dat_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head of queue; zero when empty so the response bus is quiet.
  always_comb begin
    val_o = (r_cnt != 2'd0);
    dat_o = val_o ? r_mem[r_rptr] : '0;
    cnt_o = r_cnt;
  end

endmodule

// File: rtl/db_ram_1p_ctrl.sv
// Single-port line-buffer SRAM controller: arbitrates write and read channels onto one
// RAM port, buffers read data in a 2-entry FIFO and runs a zero-fill clear sequence.
module db_ram_1p_ctrl
  import db_ram_1p_ctrl_pkg::*;
#(
  parameter int unsigned Word_Width = DB_RAM_WW,
  parameter int unsigned Addr_Width = DB_RAM_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  output logic                  busy_o,
  input  logic                  wr_val_i,
  output logic                  wr_rdy_o,
  input  logic [Addr_Width-1:0] wr_addr_i,
  input  logic [Word_Width-1:0] wr_dat_i,
  input  logic                  rd_val_i,
  output logic                  rd_rdy_o,
  input  logic [Addr_Width-1:0] rd_addr_i,
  output logic                  rd_dat_val_o,
  input  logic                  rd_dat_rdy_i,
  output logic [Word_Width-1:0] rd_dat_o,
  output logic                  ram_cen_o,
  output logic                  ram_oen_o,
  output logic                  ram_wen_o,
  output logic [Addr_Width-1:0] ram_addr_o,
  output logic [Word_Width-1:0] ram_dat_o,
  input  logic [Word_Width-1:0] ram_dat_i
);

  db_state_e             r_state;
  db_pri_e               r_pri;
  logic [Addr_Width-1:0] r_clr_cnt;
  logic                  r_rd_pend;

  logic [1:0]            w_fifo_cnt;
  logic                  w_fifo_val;
  logic [Word_Width-1:0] w_fifo_dat;
  logic                  w_run;
  logic                  w_clr_go;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_rd_ok;
  logic                  w_wr_go;
  logic                  w_rd_go;
  logic                  w_contend;
  logic                  w_last;

  // Channel handshakes and arbitration; outputs are held quiet while rst is high.
  always_comb begin
    w_run        = !rst && (r_state == ST_RUN);
    w_clr_go     = !rst && (r_state == ST_CLR);
    rd_dat_val_o = !rst && w_fifo_val;
    rd_dat_o     = rst ? '0 : w_fifo_dat;
    busy_o       = w_clr_go;
    w_pop        = rd_dat_val_o && rd_dat_rdy_i;
    // Occupancy the FIFO will reach once the in-flight read lands.
    w_occ        = {1'b0, w_fifo_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    w_rd_ok      = (w_occ < 3'd2);
    wr_rdy_o     = w_run && !(rd_val_i && w_rd_ok && (r_pri == PRI_RD));
    rd_rdy_o     = w_run && w_rd_ok && !(wr_val_i && (r_pri == PRI_WR));
    w_wr_go      = wr_val_i && wr_rdy_o;
    w_rd_go      = rd_val_i && rd_rdy_o;
    w_contend    = w_run && wr_val_i && rd_val_i && w_rd_ok;
    w_last       = (r_clr_cnt == {Addr_Width{1'b1}});
  end

  // RAM port drive, decoded from the grant of this cycle.
  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_oen_o  = rst;
    ram_addr_o = '0;
    ram_dat_o  = '0;
    if (w_clr_go) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = r_clr_cnt;
    end else if (w_wr_go) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_addr_o = wr_addr_i;
      ram_dat_o  = wr_dat_i;
    end else if (w_rd_go) begin
      ram_cen_o  = 1'b0;
      ram_addr_o = rd_addr_i;
    end
  end

  // Control FSM, priority toggle and read-pending tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_pri     <= PRI_RD;
      r_clr_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_go;
      if (w_contend) begin
        r_pri <= (r_pri == PRI_RD) ? PRI_WR : PRI_RD;
      end
      case (r_state)
        ST_RUN: begin
          if (clr_i) begin
            r_state   <= ST_CLR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLR: begin
          if (w_last) begin
            r_state   <= ST_RUN;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + {{(Addr_Width-1){1'b0}}, 1'b1};
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  db_resp_fifo #(
    .Width (Word_Width)
  ) u_resp_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (r_rd_pend),
    .pop_i  (w_pop),
    .dat_i  (ram_dat_i),
    .val_o  (w_fifo_val),
    .dat_o  (w_fifo_dat),
    .cnt_o  (w_fifo_cnt)
  );

endmodule

// File: tb/tb_db_ram_1p_ctrl.sv
// Randomized bench for db_ram_1p_ctrl against a transaction-level reference model.
module tb_db_ram_1p_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned WW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_i = 1'b0;
  logic          busy_o;
  logic          wr_val_i = 1'b0;
  logic          wr_rdy_o;
  logic [AW-1:0] wr_addr_i = '0;
  logic [WW-1:0] wr_dat_i = '0;
  logic          rd_val_i = 1'b0;
  logic          rd_rdy_o;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_dat_val_o;
  logic          rd_dat_rdy_i = 1'b0;
  logic [WW-1:0] rd_dat_o;
  logic          ram_cen_o;
  logic          ram_oen_o;
  logic          ram_wen_o;
  logic [AW-1:0] ram_addr_o;
  logic [WW-1:0] ram_dat_o;
  logic [WW-1:0] ram_dat_i;

  always #5 clk = ~clk;

  db_ram_1p_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (clr_i),
    .busy_o       (busy_o),
    .wr_val_i     (wr_val_i),
    .wr_rdy_o     (wr_rdy_o),
    .wr_addr_i    (wr_addr_i),
    .wr_dat_i     (wr_dat_i),
    .rd_val_i     (rd_val_i),
    .rd_rdy_o     (rd_rdy_o),
    .rd_addr_i    (rd_addr_i),
    .rd_dat_val_o (rd_dat_val_o),
    .rd_dat_rdy_i (rd_dat_rdy_i),
    .rd_dat_o     (rd_dat_o),
    .ram_cen_o    (ram_cen_o),
    .ram_oen_o    (ram_oen_o),
    .ram_wen_o    (ram_wen_o),
    .ram_addr_o   (ram_addr_o),
    .ram_dat_o    (ram_dat_o),
    .ram_dat_i    (ram_dat_i)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [WW-1:0] sram [256];
  logic [WW-1:0] sram_q = '0;
  always @(posedge clk) begin
    if (!ram_cen_o) begin
      if (!ram_wen_o) sram[ram_addr_o] <= ram_dat_o;
      else            sram_q <= sram[ram_addr_o];
    end
  end
  assign ram_dat_i = sram_q;

  // Reference model state.
  logic [WW-1:0] ref_mem [256];
  logic [WW-1:0] m_q [$];
  logic          m_pend = 1'b0;
  logic [WW-1:0] m_pend_dat = '0;
  logic          m_pri_wr = 1'b0;
  logic          m_busy = 1'b0;
  logic [AW-1:0] m_cnt = '0;

  int n_vec = 0;
  int n_err = 0;
  logic last_wgo = 1'b0;
  logic last_rgo = 1'b0;
  int busy_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic cyc(input logic wv, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                     input logic rv, input logic [AW-1:0] ra, input logic rr,
                     input logic cl, input logic rs);
    logic pop, rdok, run, ewr, erd, wgo, rgo, ecen;
    logic [AW-1:0] eaddr;
    int occ;
    wr_val_i = wv; wr_addr_i = wa; wr_dat_i = wd;
    rd_val_i = rv; rd_addr_i = ra; rd_dat_rdy_i = rr;
    clr_i = cl; rst = rs;
    @(negedge clk);
    if (busy_o) busy_seen++;
    if (rs) begin
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_wr_rdy", wr_rdy_o, 0);
      check_eq("rst_rd_rdy", rd_rdy_o, 0);
      check_eq("rst_rd_val", rd_dat_val_o, 0);
      check_eq("rst_rd_dat", rd_dat_o, 0);
      check_eq("rst_cen", ram_cen_o, 1);
      check_eq("rst_wen", ram_wen_o, 1);
      check_eq("rst_oen", ram_oen_o, 1);
      check_eq("rst_addr", ram_addr_o, 0);
      check_eq("rst_wdat", ram_dat_o, 0);
      @(posedge clk);
      m_q.delete(); m_pend = 1'b0; m_pri_wr = 1'b0; m_busy = 1'b0; m_cnt = '0;
      last_wgo = 1'b0; last_rgo = 1'b0;
      #1;
      return;
    end
    run  = !m_busy;
    pop  = (m_q.size() > 0) && rr;
    occ  = m_q.size() + (m_pend ? 1 : 0) - (pop ? 1 : 0);
    rdok = (occ < 2);
    ewr  = run && !(rv && rdok && !m_pri_wr);
    erd  = run && rdok && !(wv && m_pri_wr);
    wgo  = wv && ewr;
    rgo  = rv && erd;
    check_eq("busy", busy_o, m_busy);
    check_eq("wr_rdy", wr_rdy_o, ewr);
    check_eq("rd_rdy", rd_rdy_o, erd);
    check_eq("rd_val", rd_dat_val_o, m_q.size() > 0);
    if (m_q.size() > 0) check_eq("rd_dat", rd_dat_o, m_q[0]);
    check_eq("oen", ram_oen_o, 0);
    ecen = 1'b0;
    eaddr = '0;
    if (m_busy)   eaddr = m_cnt;
    else if (wgo) eaddr = wa;
    else if (rgo) eaddr = ra;
    else          ecen = 1'b1;
    check_eq("ram_cen", ram_cen_o, ecen);
    if (!ecen) begin
      check_eq("ram_addr", ram_addr_o, eaddr);
      check_eq("ram_wen", ram_wen_o, rgo && !m_busy);
      if (m_busy)   check_eq("ram_clr_dat", ram_dat_o, 0);
      else if (wgo) check_eq("ram_wr_dat", ram_dat_o, wd);
    end
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (m_pend) m_q.push_back(m_pend_dat);
    m_pend = rgo;
    if (rgo) m_pend_dat = ref_mem[ra];
    if (wgo) ref_mem[wa] = wd;
    if (wv && rv && rdok && run) m_pri_wr = !m_pri_wr;
    if (m_busy) begin
      ref_mem[m_cnt] = '0;
      if (m_cnt == 8'hFF) m_busy = 1'b0;
      m_cnt = m_cnt + 8'd1;
    end else if (cl) begin
      m_busy = 1'b1;
      m_cnt = '0;
    end
    last_wgo = wgo;
    last_rgo = rgo;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic [WW-1:0] rnd_dat();
    return WW'($urandom());
  endfunction

  initial begin
    int nrd, nwr, nacc;
    logic first_rd;

    // Reset.
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Fill every address with random data.
    for (int a = 0; a < 256; a++) cyc(1'b1, AW'(a), rnd_dat(), 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Write then read address 7 on the next cycle.
    cyc(1'b1, 8'd7, 20'h12345, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back reads 0..15.
    for (int a = 0; a < 16; a++) cyc(1'b0, '0, '0, 1'b1, AW'(a), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reads under response backpressure.
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, '0, 1'b1, AW'(32 + i), 1'b0, 1'b0, 1'b0);
      if (last_rgo) nacc++;
    end
    check_eq("bp_accepted", nacc, 2);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, '0, 1'b1, AW'(40 + i), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Contention: strict alternation starting with the read.
    nrd = 0; nwr = 0; first_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, AW'($urandom_range(0, 15)), rnd_dat(), 1'b1, AW'($urandom_range(0, 15)),
          1'b1, 1'b0, 1'b0);
      if (i == 0) first_rd = last_rgo;
      if (last_rgo) nrd++;
      if (last_wgo) nwr++;
    end
    check_eq("cont_first_rd", first_rd, 1);
    check_eq("cont_rd", nrd, 4);
    check_eq("cont_wr", nwr, 4);
    idle(3);

    // Full clear after filling with ones.
    for (int a = 0; a < 256; a++) cyc(1'b1, AW'(a), 20'hFFFFF, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    busy_seen = 0;
    for (int i = 0; i < 260; i++) begin
      cyc($urandom_range(0, 1) == 1, AW'($urandom()), rnd_dat(), $urandom_range(0, 1) == 1,
          AW'($urandom()), 1'b1, 1'b0, 1'b0);
    end
    check_eq("clr_busy_cycles", busy_seen, 256);
    idle(3);
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 8'd128, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset during a clear with two responses pending.
    cyc(1'b1, 8'd200, 20'hABCDE, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), rnd_dat(),
          $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
          $urandom_range(0, 599) == 0);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
